// File: rtl/mmem_port_ctl.sv
// M-memory port controller: arbitrates RAM port A between CPU writeback,
// spy bus and the power-up clear sequencer; port B carries CPU reads.
module mmem_port_ctl #(
    parameter int AW          = 5,
    parameter int DW          = 32,
    parameter int DEPTH       = 32,
    parameter int SPY_MAXWAIT = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cpu_wr_req,
    input  logic [AW-1:0] cpu_wr_addr,
    input  logic [DW-1:0] cpu_wr_data,
    output logic          cpu_wr_ready,
    input  logic          cpu_rd_en,
    input  logic [AW-1:0] cpu_rd_addr,
    input  logic          spy_req,
    input  logic          spy_we,
    input  logic [AW-1:0] spy_addr,
    input  logic [DW-1:0] spy_wdata,
    output logic          spy_ack,
    output logic [DW-1:0] spy_rdata,
    output logic          init_done,
    output logic          ram_reset,
    output logic [AW-1:0] ram_addr_a,
    output logic [DW-1:0] ram_data_a,
    output logic          ram_wren_a,
    output logic          ram_rden_a,
    output logic [AW-1:0] ram_addr_b,
    output logic          ram_wren_b,
    output logic          ram_rden_b,
    input  logic [DW-1:0] ram_q_a
);

    localparam int SW = $clog2(SPY_MAXWAIT + 1);

    localparam logic [1:0] S_INIT    = 2'd0;
    localparam logic [1:0] S_IDLE    = 2'd1;
    localparam logic [1:0] S_SPY_RD  = 2'd2;
    localparam logic [1:0] S_SPY_REL = 2'd3;

    localparam logic [SW-1:0] STARVE_MAX = SW'(SPY_MAXWAIT);
    localparam logic [AW-1:0] INIT_LAST  = AW'(DEPTH - 1);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] init_cnt_q, init_cnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          spy_ack_q, spy_ack_d;
    logic [DW-1:0] spy_rdata_q, spy_rdata_d;
    logic          init_done_q, init_done_d;
    logic          spy_wins;

    assign spy_wins = spy_req && (!cpu_wr_req || starve_q == STARVE_MAX);

    // Next-state and port-A decode from current state and requests
    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        starve_d     = starve_q;
        spy_ack_d    = 1'b0;
        spy_rdata_d  = spy_rdata_q;
        init_done_d  = init_done_q;
        cpu_wr_ready = 1'b0;
        ram_addr_a   = '0;
        ram_data_a   = '0;
        ram_wren_a   = 1'b0;
        ram_rden_a   = 1'b0;
        unique case (state_q)
            S_INIT: begin
                ram_wren_a = 1'b1;
                ram_addr_a = init_cnt_q;
                init_cnt_d = init_cnt_q + AW'(1);
                if (init_cnt_q == INIT_LAST) begin
                    init_cnt_d  = '0;
                    init_done_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_IDLE: begin
                if (spy_wins) begin
                    starve_d   = '0;
                    ram_addr_a = spy_addr;
                    if (spy_we) begin
                        ram_wren_a = 1'b1;
                        ram_data_a = spy_wdata;
                        spy_ack_d  = 1'b1;
                        state_d    = S_SPY_REL;
                    end else begin
                        ram_rden_a = 1'b1;
                        state_d    = S_SPY_RD;
                    end
                end else begin
                    cpu_wr_ready = 1'b1;
                    if (cpu_wr_req) begin
                        ram_wren_a = 1'b1;
                        ram_addr_a = cpu_wr_addr;
                        ram_data_a = cpu_wr_data;
                    end
                    if (spy_req && starve_q != STARVE_MAX) begin
                        starve_d = starve_q + SW'(1);
                    end
                end
            end
            S_SPY_RD: begin
                spy_rdata_d = ram_q_a;
                spy_ack_d   = 1'b1;
                state_d     = S_SPY_REL;
            end
            S_SPY_REL: begin
                cpu_wr_ready = 1'b1;
                if (cpu_wr_req) begin
                    ram_wren_a = 1'b1;
                    ram_addr_a = cpu_wr_addr;
                    ram_data_a = cpu_wr_data;
                end
                if (!spy_req) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // State registers; reset drops any transaction and restarts the clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            starve_q    <= '0;
            spy_ack_q   <= 1'b0;
            spy_rdata_q <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            starve_q    <= starve_d;
            spy_ack_q   <= spy_ack_d;
            spy_rdata_q <= spy_rdata_d;
            init_done_q <= init_done_d;
        end
    end

    assign spy_ack    = spy_ack_q;
    assign spy_rdata  = spy_rdata_q;
    assign init_done  = init_done_q;
    assign ram_reset  = (state_q == S_INIT);
    assign ram_addr_b = cpu_rd_addr;
    assign ram_rden_b = cpu_rd_en && init_done_q;
    assign ram_wren_b = 1'b0;

endmodule

// File: tb/tb_mmem_port_ctl.sv
// Bench for mmem_port_ctl: behavioural dual-port RAM, directed
// stimulus, and scoreboards for spy acks and port-B read data.
module tb_mmem_port_ctl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_wr_req;
    logic [4:0]  cpu_wr_addr;
    logic [31:0] cpu_wr_data;
    logic        cpu_wr_ready;
    logic        cpu_rd_en;
    logic [4:0]  cpu_rd_addr;
    logic        spy_req;
    logic        spy_we;
    logic [4:0]  spy_addr;
    logic [31:0] spy_wdata;
    logic        spy_ack;
    logic [31:0] spy_rdata;
    logic        init_done;
    logic        ram_reset;
    logic [4:0]  ram_addr_a;
    logic [31:0] ram_data_a;
    logic        ram_wren_a;
    logic        ram_rden_a;
    logic [4:0]  ram_addr_b;
    logic        ram_wren_b;
    logic        ram_rden_b;
    logic [31:0] ram_q_a;
    logic [31:0] ram_q_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [32];
    logic        rdb_v = 1'b0;
    logic [31:0] spy_exp_q [$];
    logic [31:0] rdb_exp_q [$];

    always #5 clk = ~clk;

    mmem_port_ctl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cpu_wr_req   (cpu_wr_req),
        .cpu_wr_addr  (cpu_wr_addr),
        .cpu_wr_data  (cpu_wr_data),
        .cpu_wr_ready (cpu_wr_ready),
        .cpu_rd_en    (cpu_rd_en),
        .cpu_rd_addr  (cpu_rd_addr),
        .spy_req      (spy_req),
        .spy_we       (spy_we),
        .spy_addr     (spy_addr),
        .spy_wdata    (spy_wdata),
        .spy_ack      (spy_ack),
        .spy_rdata    (spy_rdata),
        .init_done    (init_done),
        .ram_reset    (ram_reset),
        .ram_addr_a   (ram_addr_a),
        .ram_data_a   (ram_data_a),
        .ram_wren_a   (ram_wren_a),
        .ram_rden_a   (ram_rden_a),
        .ram_addr_b   (ram_addr_b),
        .ram_wren_b   (ram_wren_b),
        .ram_rden_b   (ram_rden_b),
        .ram_q_a      (ram_q_a)
    );

    // RAM model: registered outputs, read-during-write returns old data
    always @(posedge clk) begin
        if (ram_wren_a) mem[ram_addr_a] <= ram_data_a;
        if (ram_wren_b) mem[ram_addr_b] <= 32'hBAD0BAD0;
        if (ram_rden_a) ram_q_a <= mem[ram_addr_a];
        if (ram_rden_b) ram_q_b <= mem[ram_addr_b];
        rdb_v <= ram_rden_b;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops scoreboards whenever the DUT/RAM presents a response
    always @(negedge clk) begin
        if (spy_ack === 1'b1) begin
            if (spy_exp_q.size() == 0) begin
                chk("spy_ack unexpected", 64'd1, 64'd0);
            end else begin
                chk("spy_rdata", {32'd0, spy_rdata},
                    {32'd0, spy_exp_q.pop_front()});
            end
        end
        if (rdb_v) begin
            if (rdb_exp_q.size() == 0) begin
                chk("q_b unexpected", 64'd1, 64'd0);
            end else begin
                chk("q_b", {32'd0, ram_q_b},
                    {32'd0, rdb_exp_q.pop_front()});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic init_seq();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk("init_write",
                {29'd0, ram_wren_a, cpu_wr_ready, ram_reset, ram_addr_a, ram_data_a},
                {29'd0, 1'b1, 1'b0, 1'b1, 5'(i), 32'd0});
        end
        @(negedge clk);
        chk("init_done", {61'd0, init_done, cpu_wr_ready, ram_reset},
            {61'd0, 1'b1, 1'b1, 1'b0});
    endtask

    task automatic cpu_write(input logic [4:0] a, input logic [31:0] d);
        cpu_wr_req  = 1'b1;
        cpu_wr_addr = a;
        cpu_wr_data = d;
        @(negedge clk);
        chk("cpu_wr_ready", {63'd0, cpu_wr_ready}, 64'd1);
        cyc();
        cpu_wr_req = 1'b0;
    endtask

    task automatic cpu_read(input logic [4:0] a, input logic [31:0] e);
        cpu_rd_en   = 1'b1;
        cpu_rd_addr = a;
        rdb_exp_q.push_back(e);
        cyc();
        cpu_rd_en = 1'b0;
    endtask

    task automatic spy_txn(input logic we, input logic [4:0] a,
                           input logic [31:0] wd, input logic [31:0] erd,
                           input int lat);
        int n;
        spy_req   = 1'b1;
        spy_we    = we;
        spy_addr  = a;
        spy_wdata = wd;
        spy_exp_q.push_back(erd);
        @(negedge clk);
        chk("spy_grant",
            {26'd0, cpu_wr_ready, ram_wren_a, ram_rden_a, ram_addr_a},
            {26'd0, 1'b0, we, !we, a});
        if (we) chk("spy_wdata_a", {32'd0, ram_data_a}, {32'd0, wd});
        n = 0;
        do begin
            cyc();
            n++;
        end while (spy_ack !== 1'b1 && n < 10);
        chk("spy_latency", 64'(n), 64'(lat));
        spy_req = 1'b0;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        reset_n     = 1'b0;
        cpu_wr_req  = 1'b0;
        cpu_wr_addr = '0;
        cpu_wr_data = '0;
        cpu_rd_en   = 1'b0;
        cpu_rd_addr = '0;
        spy_req     = 1'b0;
        spy_we      = 1'b0;
        spy_addr    = '0;
        spy_wdata   = '0;
        repeat (2) cyc();
        chk("reset_state",
            {60'd0, spy_ack, init_done, ram_reset, ram_wren_b},
            {60'd0, 1'b0, 1'b0, 1'b1, 1'b0});
        chk("reset_rdata", {32'd0, spy_rdata}, 64'd0);

        // Power-up clear with a CPU write held off until it completes
        cpu_wr_req  = 1'b1;
        cpu_wr_addr = 5'd3;
        cpu_wr_data = 32'h33;
        reset_n     = 1'b1;
        init_seq();
        chk("held_cpu_wr", {26'd0, ram_wren_a, ram_addr_a, ram_data_a},
            {26'd0, 1'b1, 5'd3, 32'h33});
        cyc();
        cpu_wr_req = 1'b0;
        cpu_write(5'd7, 32'hDEADBEEF);

        // Spy write then CPU read-back over port B
        spy_txn(1'b1, 5'd5, 32'h12345678, 32'd0, 1);
        cpu_read(5'd5, 32'h12345678);
        cpu_read(5'd3, 32'h33);

        // Spy read, data held after release
        spy_txn(1'b0, 5'd7, 32'd0, 32'hDEADBEEF, 2);
        cyc();
        cyc();
        chk("rdata_held", {32'd0, spy_rdata}, {32'd0, 32'hDEADBEEF});

        // Same-address read and write in one cycle returns old data
        cpu_wr_req  = 1'b1;
        cpu_wr_addr = 5'd5;
        cpu_wr_data = 32'h55;
        cpu_read(5'd5, 32'h12345678);
        cpu_wr_req = 1'b0;
        cpu_read(5'd5, 32'h55);

        // Starvation: CPU streams writes, spy preempts after 8 cycles
        spy_req   = 1'b1;
        spy_we    = 1'b1;
        spy_addr  = 5'd20;
        spy_wdata = 32'hA5A5A5A5;
        spy_exp_q.push_back(32'hDEADBEEF);
        w = 0;
        for (int k = 0; k < 10; k++) begin
            cpu_wr_req  = 1'b1;
            cpu_wr_addr = 5'(10 + w);
            cpu_wr_data = 32'h100 + 32'(w);
            @(negedge clk);
            chk("starve_ready", {63'd0, cpu_wr_ready}, {63'd0, k != 8});
            if (k == 8) begin
                chk("starve_grant", {58'd0, ram_wren_a, ram_addr_a},
                    {58'd0, 1'b1, 5'd20});
            end
            if (cpu_wr_ready) w++;
            cyc();
            if (spy_ack) spy_req = 1'b0;
        end
        cpu_wr_req = 1'b0;
        chk("starve_cpu_count", 64'(w), 64'd9);
        cpu_read(5'd20, 32'hA5A5A5A5);
        cpu_read(5'd17, 32'h107);
        cpu_read(5'd18, 32'h108);

        // Spy request held high after ack: served exactly once
        spy_req   = 1'b1;
        spy_we    = 1'b1;
        spy_addr  = 5'd9;
        spy_wdata = 32'h99;
        spy_exp_q.push_back(32'hDEADBEEF);
        cyc();
        chk("hold_ack", {63'd0, spy_ack}, 64'd1);
        cyc();
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("hold_no_regrant", {62'd0, ram_wren_a, spy_ack}, 64'd0);
            cyc();
        end
        spy_req = 1'b0;
        cyc();
        spy_txn(1'b0, 5'd9, 32'd0, 32'h99, 2);

        // Reset in the middle of a spy read
        spy_req  = 1'b1;
        spy_we   = 1'b0;
        spy_addr = 5'd3;
        cyc();
        reset_n = 1'b0;
        spy_req = 1'b0;
        #1;
        chk("mid_reset",
            {56'd0, spy_ack, init_done, ram_reset, ram_addr_a},
            {56'd0, 1'b0, 1'b0, 1'b1, 5'd0});
        chk("mid_reset_rdata", {32'd0, spy_rdata}, 64'd0);
        cyc();
        cyc();
        reset_n = 1'b1;
        init_seq();
        cyc();
        cpu_read(5'd3, 32'd0);
        cpu_read(5'd7, 32'd0);
        cyc();
        cyc();

        chk("spy_q_empty", 64'(spy_exp_q.size()), 64'd0);
        chk("rdb_q_empty", 64'(rdb_exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
